// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: FIFO-buffered start/done stimulus driver for TinyALU with done-timeout and idle gap.
// Define ALU_DRV_RAND_GAP_EN to take the idle gap from a 16-bit LFSR instead of gap_cfg.
module alu_cmd_driver #(
    parameter int DATA_W  = 8,
    parameter int OP_W    = 3,
    parameter int DEPTH   = 4,
    parameter int GAP_W   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [OP_W-1:0]            cmd_op,
    input  logic [DATA_W-1:0]          cmd_a,
    input  logic [DATA_W-1:0]          cmd_b,
    input  logic [GAP_W-1:0]           gap_cfg,
    output logic                       start,
    output logic [OP_W-1:0]            op,
    output logic [DATA_W-1:0]          a,
    output logic [DATA_W-1:0]          b,
    input  logic                       done,
    input  logic                       pred_ready,
    output logic                       pred_valid,
    output logic [OP_W-1:0]            pred_op,
    output logic [DATA_W-1:0]          pred_a,
    output logic [DATA_W-1:0]          pred_b,
    output logic                       timeout_err,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam int ENT_W = OP_W + 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [ENT_W-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;

    logic              start_q, start_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              pred_valid_q, pred_valid_d;
    logic [OP_W-1:0]   pred_op_q, pred_op_d;
    logic [DATA_W-1:0] pred_a_q, pred_a_d;
    logic [DATA_W-1:0] pred_b_q, pred_b_d;
    logic              timeout_err_q, timeout_err_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;

    logic              push;
    logic              pop;
    logic              tmo_hit;
    logic              issue_exit;
    logic              timed_out;
    logic [GAP_W-1:0]  gap_val;
    logic [ENT_W-1:0]  pop_ent;

    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state_q == IDLE) && (count_q != '0) && pred_ready;
    assign pop_ent    = mem_q[rd_ptr_q];
    assign tmo_hit    = (tmo_q == TMO_W'(TIMEOUT - 1));
    assign issue_exit = (state_q == ISSUE) && ((op_q == '0) || done || tmo_hit);
    assign timed_out  = (state_q == ISSUE) && (op_q != '0) && !done && tmo_hit;

`ifdef ALU_DRV_RAND_GAP_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;
    logic        unused_gap_cfg;

    assign unused_gap_cfg = ^gap_cfg;
    assign lfsr_fb        = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    // The gap uses the current LFSR value; the register steps at that same exit edge.
    assign gap_val        = lfsr_q[GAP_W-1:0];

    always_comb begin
        lfsr_d = lfsr_q;
        if (issue_exit) begin
            lfsr_d = {lfsr_q[14:0], lfsr_fb};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign gap_val = gap_cfg;
`endif

    // Full is registered so a pop while full only frees cmd_ready on the following cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {cmd_op, cmd_a, cmd_b};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_exit) begin
                    state_d = (gap_val == '0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q <= GAP_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_d       = start_q;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        pred_valid_d  = 1'b0;
        pred_op_d     = pred_op_q;
        pred_a_d      = pred_a_q;
        pred_b_d      = pred_b_q;
        timeout_err_d = timeout_err_q;
        tmo_d         = tmo_q;
        gap_cnt_d     = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    {op_d, a_d, b_d}                = pop_ent;
                    {pred_op_d, pred_a_d, pred_b_d} = pop_ent;
                    start_d                         = 1'b1;
                    pred_valid_d                    = 1'b1;
                    tmo_d                           = '0;
                end
            end
            ISSUE: begin
                if (issue_exit) begin
                    start_d   = 1'b0;
                    gap_cnt_d = gap_val;
                    if (timed_out) begin
                        timeout_err_d = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
            default: start_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            start_q       <= 1'b0;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            pred_valid_q  <= 1'b0;
            pred_op_q     <= '0;
            pred_a_q      <= '0;
            pred_b_q      <= '0;
            timeout_err_q <= 1'b0;
            tmo_q         <= '0;
            gap_cnt_q     <= '0;
        end else begin
            start_q       <= start_d;
            op_q          <= op_d;
            a_q           <= a_d;
            b_q           <= b_d;
            pred_valid_q  <= pred_valid_d;
            pred_op_q     <= pred_op_d;
            pred_a_q      <= pred_a_d;
            pred_b_q      <= pred_b_d;
            timeout_err_q <= timeout_err_d;
            tmo_q         <= tmo_d;
            gap_cnt_q     <= gap_cnt_d;
        end
    end

    assign cmd_ready   = reset_n && !full_q;
    assign start       = start_q;
    assign op          = op_q;
    assign a           = a_q;
    assign b           = b_q;
    assign pred_valid  = pred_valid_q;
    assign pred_op     = pred_op_q;
    assign pred_a      = pred_a_q;
    assign pred_b      = pred_b_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != IDLE) || (count_q != '0);
    assign fifo_count  = count_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: randomized bench for alu_cmd_driver against a transaction-level model
// (queue of commands, op-duration and idle-gap rules).
module tb_alu_cmd_driver;

    localparam int DATA_W  = 8;
    localparam int OP_W    = 3;
    localparam int DEPTH   = 4;
    localparam int GAP_W   = 2;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENT_W   = OP_W + 2 * DATA_W;

    logic              clk;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [GAP_W-1:0]  gap_cfg;
    logic              start;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              done;
    logic              pred_ready;
    logic              pred_valid;
    logic [OP_W-1:0]   pred_op;
    logic [DATA_W-1:0] pred_a;
    logic [DATA_W-1:0] pred_b;
    logic              timeout_err;
    logic              busy;
    logic [CNT_W-1:0]  fifo_count;

    alu_cmd_driver #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W),
        .DEPTH  (DEPTH),
        .GAP_W  (GAP_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .gap_cfg    (gap_cfg),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .done       (done),
        .pred_ready (pred_ready),
        .pred_valid (pred_valid),
        .pred_op    (pred_op),
        .pred_a     (pred_a),
        .pred_b     (pred_b),
        .timeout_err(timeout_err),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int testCount = 0;
    int failCount = 0;

    // Stimulus knobs, percent (reset in per-mille).
    int pValid;
    int pDone;
    int pPred;
    int pNop;
    int pReset;

    // Model: pending commands, the command on the pins, how long it has been high,
    // and how many low cycles have passed against the gap owed after the last op.
    logic [ENT_W-1:0] modelQueue[$];
    logic [ENT_W-1:0] modelCur;
    bit               modelInOp;
    int               modelHigh;
    int               modelLow;
    int               modelGap;
    bit               modelErr;
    bit               modelPulse;
    logic [15:0]      modelLfsr;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, observed, expected);
        end
    endtask

    function automatic logic [OP_W-1:0] opOf(input logic [ENT_W-1:0] e);
        return e[ENT_W-1 -: OP_W];
    endfunction

    function automatic logic [DATA_W-1:0] aOf(input logic [ENT_W-1:0] e);
        return e[2*DATA_W-1 -: DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] bOf(input logic [ENT_W-1:0] e);
        return e[DATA_W-1:0];
    endfunction

    task automatic modelReset();
        modelQueue.delete();
        modelCur   = '0;
        modelInOp  = 1'b0;
        modelHigh  = 0;
        modelLow   = 0;
        modelGap   = 0;
        modelErr   = 1'b0;
        modelPulse = 1'b0;
        modelLfsr  = 16'hACE1;
    endtask

    task automatic modelStep();
        bit   canPush;
        int   g;
        logic fb;
        if (!reset_n) begin
            modelReset();
            return;
        end
        canPush    = cmd_valid && (modelQueue.size() != DEPTH);
        modelPulse = 1'b0;
        if (modelInOp) begin
            if (opOf(modelCur) == 0 || done || modelHigh + 1 == TIMEOUT) begin
                if (opOf(modelCur) != 0 && !done) modelErr = 1'b1;
`ifdef ALU_DRV_RAND_GAP_EN
                g         = int'(modelLfsr) % (1 << GAP_W);
                fb        = ^(modelLfsr & 16'hB400);
                modelLfsr = {modelLfsr[14:0], fb};
`else
                g  = int'(gap_cfg);
                fb = 1'b0;
`endif
                modelInOp = 1'b0;
                modelLow  = 0;
                modelGap  = g;
            end else begin
                modelHigh++;
            end
        end else if (modelLow >= modelGap && modelQueue.size() > 0 && pred_ready) begin
            modelCur   = modelQueue.pop_front();
            modelInOp  = 1'b1;
            modelHigh  = 0;
            modelPulse = 1'b1;
        end else begin
            modelLow++;
        end
        if (canPush) modelQueue.push_back({cmd_op, cmd_a, cmd_b});
    endtask

    task automatic compareAll();
        checkOutput("cmd_ready", cmd_ready, reset_n && (modelQueue.size() != DEPTH));
        checkOutput("start", start, modelInOp);
        checkOutput("op", op, opOf(modelCur));
        checkOutput("a", a, aOf(modelCur));
        checkOutput("b", b, bOf(modelCur));
        checkOutput("pred_valid", pred_valid, modelPulse);
        checkOutput("pred_op", pred_op, opOf(modelCur));
        checkOutput("pred_a", pred_a, aOf(modelCur));
        checkOutput("pred_b", pred_b, bOf(modelCur));
        checkOutput("timeout_err", timeout_err, modelErr);
        checkOutput("busy", busy, modelInOp || (modelLow < modelGap) || (modelQueue.size() > 0));
        checkOutput("fifo_count", fifo_count, modelQueue.size());
    endtask

    task automatic applyStimulus();
        reset_n    = !(($urandom % 1000) < pReset);
        cmd_valid  = ($urandom % 100) < pValid;
        cmd_op     = (($urandom % 100) < pNop) ? '0 : OP_W'($urandom_range(1, (1 << OP_W) - 1));
        cmd_a      = DATA_W'($urandom);
        cmd_b      = DATA_W'($urandom);
        gap_cfg    = GAP_W'($urandom);
        done       = ($urandom % 100) < pDone;
        pred_ready = ($urandom % 100) < pPred;
    endtask

    task automatic runPhase(input int cycles, input int v, input int d, input int p, input int n, input int r);
        pValid = v;
        pDone  = d;
        pPred  = p;
        pNop   = n;
        pReset = r;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            compareAll();
            applyStimulus();
            @(posedge clk);
            modelStep();
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = '0;
        cmd_a      = '0;
        cmd_b      = '0;
        gap_cfg    = '0;
        done       = 1'b0;
        pred_ready = 1'b0;
        modelReset();

        runPhase(4,    0,  0,   0,  0, 1000);
        runPhase(400,  50, 40,  90, 15, 0);
        runPhase(700,  80, 0,   90, 10, 0);
        runPhase(400,  40, 50,  20, 15, 0);
        runPhase(1000, 60, 30,  80, 20, 20);
        runPhase(400,  70, 60,  100, 50, 0);
        runPhase(300,  30, 100, 100, 0, 0);
        runPhase(3,    0,  0,   0,  0, 1000);
        runPhase(20,   0,  100, 100, 0, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
